// File: rtl/svreal_mac_pkg.sv
// Shared types and exponent helpers for the svreal multiply-accumulate.
// Default formats live here so the top and any wrappers agree on them.
package svreal_mac_pkg;

  typedef enum logic {
    SAT  = 1'b0,
    WRAP = 1'b1
  } ovf_mode_t;

  function automatic int prod_exp(input int a_exp, input int b_exp);
    return a_exp + b_exp;
  endfunction

  // Moving to a smaller exponent is a left shift, otherwise a flooring right shift.
  function automatic int shl_amt(input int from_exp, input int to_exp);
    return (from_exp > to_exp) ? (from_exp - to_exp) : 0;
  endfunction

  function automatic int shr_amt(input int from_exp, input int to_exp);
    return (from_exp > to_exp) ? 0 : (to_exp - from_exp);
  endfunction

  localparam int DEF_A_WIDTH   = 16;
  localparam int DEF_A_EXP     = -8;
  localparam int DEF_B_WIDTH   = 17;
  localparam int DEF_B_EXP     = -9;
  localparam int DEF_ACC_WIDTH = 40;
  localparam int DEF_ACC_EXP   = -17;
  localparam int DEF_OUT_WIDTH = 18;
  localparam int DEF_OUT_EXP   = -10;

  localparam int DEF_PROD_EXP    = prod_exp(DEF_A_EXP, DEF_B_EXP);
  localparam int PROD_TO_ACC_SHL = shl_amt(DEF_PROD_EXP, DEF_ACC_EXP);
  localparam int PROD_TO_ACC_SHR = shr_amt(DEF_PROD_EXP, DEF_ACC_EXP);
  localparam int ACC_TO_OUT_SHL  = shl_amt(DEF_ACC_EXP, DEF_OUT_EXP);
  localparam int ACC_TO_OUT_SHR  = shr_amt(DEF_ACC_EXP, DEF_OUT_EXP);

endpackage

// File: rtl/svreal_align_sat.sv
// Combinational exponent alignment followed by a clamp or wrap into the
// target width; ovf_o flags any value that did not fit.
module svreal_align_sat
  import svreal_mac_pkg::*;
#(
  parameter int        IN_W    = 40,
  parameter int        IN_EXP  = -17,
  parameter int        OUT_W   = 18,
  parameter int        OUT_EXP = -10,
  parameter ovf_mode_t MODE    = SAT
) (
  input  logic [IN_W-1:0]  value_i,
  output logic [OUT_W-1:0] value_o,
  output logic             ovf_o
);

  localparam int SHL = shl_amt(IN_EXP, OUT_EXP);
  localparam int SHR = shr_amt(IN_EXP, OUT_EXP);
  localparam int MW  = IN_W + SHL;

  logic signed [MW-1:0] ext;
  logic signed [MW-1:0] shifted;

  assign ext     = MW'($signed(value_i));
  assign shifted = (ext <<< SHL) >>> SHR;

  generate
    if (MW > OUT_W) begin : g_check
      // The value fits when every bit from the target sign bit upward agrees.
      logic [MW-OUT_W:0] top_bits;
      assign top_bits = shifted[MW-1:OUT_W-1];
      assign ovf_o    = !((&top_bits) || !(|top_bits));

      always_comb begin
        value_o = shifted[OUT_W-1:0];
        if (ovf_o && (MODE == SAT)) begin
          value_o = {shifted[MW-1], {(OUT_W-1){!shifted[MW-1]}}};
        end
      end
    end else begin : g_fit
      assign value_o = OUT_W'(shifted);
      assign ovf_o   = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/svreal_mac.sv
// Four-register pipelined fixed-point MAC: product, accumulate, output align,
// output buffer. One global enable stalls every stage while a result waits.
module svreal_mac
  import svreal_mac_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int A_EXP     = DEF_A_EXP,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int B_EXP     = DEF_B_EXP,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int ACC_EXP   = DEF_ACC_EXP,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int OUT_EXP   = DEF_OUT_EXP,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [A_WIDTH-1:0]   a_value,
  input  logic [B_WIDTH-1:0]   b_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_value,
  output logic                 out_ovf
);

  localparam ovf_mode_t MODE = (SATURATE != 0) ? SAT : WRAP;
  localparam int PW    = A_WIDTH + B_WIDTH;
  localparam int PE    = prod_exp(A_EXP, B_EXP);
  localparam int P_SHL = shl_amt(PE, ACC_EXP);
  localparam int P_SHR = shr_amt(PE, ACC_EXP);
  localparam int APW   = PW + P_SHL;
  localparam int SW    = ((APW > ACC_WIDTH) ? APW : ACC_WIDTH) + 1;

  logic ce;

  logic                    first_q;
  logic                    s1_valid_q, s1_first_q, s1_last_q;
  logic signed [PW-1:0]    prod_q, prod_d;

  logic signed [APW-1:0]   prod_al;
  logic signed [SW-1:0]    acc_base, sum_d;
  logic [ACC_WIDTH-1:0]    acc_d;
  logic                    acc_ovf;
  logic                    s2_valid_q, s2_last_q, frame_ovf_q;
  logic signed [ACC_WIDTH-1:0] acc_q;

  logic [OUT_WIDTH-1:0]    res_d;
  logic                    res_ovf;
  logic                    s3_valid_q, s3_ovf_q;
  logic [OUT_WIDTH-1:0]    s3_value_q;

  logic                    out_valid_q, out_ovf_q;
  logic [OUT_WIDTH-1:0]    out_value_q;

  assign ce       = !out_valid_q || out_ready;
  assign in_ready = ce;

  assign prod_d = PW'($signed(a_value)) * PW'($signed(b_value));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q    <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      prod_q     <= '0;
    end else if (ce) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        prod_q     <= prod_d;
        s1_first_q <= first_q;
        s1_last_q  <= in_last;
        first_q    <= in_last;
      end
    end
  end

  assign prod_al = (APW'(prod_q) <<< P_SHL) >>> P_SHR;

  // A frame's first beat replaces the accumulator instead of adding to it.
  always_comb begin
    acc_base = SW'(acc_q);
    if (s1_first_q) begin
      acc_base = '0;
    end
    sum_d = acc_base + SW'(prod_al);
  end

  svreal_align_sat #(
    .IN_W   (SW),
    .IN_EXP (ACC_EXP),
    .OUT_W  (ACC_WIDTH),
    .OUT_EXP(ACC_EXP),
    .MODE   (MODE)
  ) u_acc_align (
    .value_i(sum_d),
    .value_o(acc_d),
    .ovf_o  (acc_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      frame_ovf_q <= 1'b0;
    end else if (ce) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_last_q   <= s1_last_q;
        acc_q       <= acc_d;
        frame_ovf_q <= acc_ovf | (frame_ovf_q & !s1_first_q);
      end
    end
  end

  svreal_align_sat #(
    .IN_W   (ACC_WIDTH),
    .IN_EXP (ACC_EXP),
    .OUT_W  (OUT_WIDTH),
    .OUT_EXP(OUT_EXP),
    .MODE   (MODE)
  ) u_out_align (
    .value_i(acc_q),
    .value_o(res_d),
    .ovf_o  (res_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s3_valid_q <= 1'b0;
      s3_value_q <= '0;
      s3_ovf_q   <= 1'b0;
    end else if (ce) begin
      s3_valid_q <= s2_valid_q && s2_last_q;
      if (s2_valid_q && s2_last_q) begin
        s3_value_q <= res_d;
        s3_ovf_q   <= frame_ovf_q | res_ovf;
      end
    end
  end

  // Consuming and reloading can coincide; the new result simply replaces the old.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_ovf_q   <= 1'b0;
    end else if (ce) begin
      out_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        out_value_q <= s3_value_q;
        out_ovf_q   <= s3_ovf_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_svreal_mac.sv
// Drives a saturating and a wrapping MAC with identical beats and checks each
// frame result against an integer model of the fixed-point rules.
module tb_svreal_mac;

  localparam int AW      = 16;
  localparam int BW      = 17;
  localparam int OW      = 18;
  localparam int ACC_W   = 40;
  localparam int PEXP    = -17;
  localparam int ACC_EXP = -17;
  localparam int OUT_EXP = -10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [AW-1:0] a_value = '0;
  logic [BW-1:0] b_value = '0;

  logic in_ready_s, in_ready_w, out_valid_s, out_valid_w, out_ovf_s, out_ovf_w;
  logic signed [OW-1:0] out_value_s, out_value_w;

  int n_checks = 0;
  int n_errors = 0;
  int n_results = 0;
  bit rand_ready = 1'b0;
  int gap_pct = 0;

  typedef struct {
    longint v_sat;
    bit     o_sat;
    longint v_wrap;
    bit     o_wrap;
  } exp_t;

  exp_t   exp_q[$];
  longint frame_a[$];
  longint frame_b[$];

  always #5 clk = ~clk;

  svreal_mac #(.SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_last(in_last), .a_value(a_value), .b_value(b_value),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_value(out_value_s),
    .out_ovf(out_ovf_s)
  );

  svreal_mac #(.SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_last(in_last), .a_value(a_value), .b_value(b_value),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_value(out_value_w),
    .out_ovf(out_ovf_w)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint pow2(input int n);
    return longint'(1) << n;
  endfunction

  function automatic longint floor_div(input longint x, input longint d);
    longint q;
    q = x / d;
    if ((x % d != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint align(input longint x, input int from_exp, input int to_exp);
    if (from_exp > to_exp) return x * pow2(from_exp - to_exp);
    return floor_div(x, pow2(to_exp - from_exp));
  endfunction

  function automatic void fit(input longint x, input int w, input bit sat,
                              output longint y, output bit ovf);
    longint lo, hi, m;
    lo  = -pow2(w - 1);
    hi  = pow2(w - 1) - 1;
    m   = pow2(w);
    ovf = (x < lo) || (x > hi);
    if (!ovf) y = x;
    else if (sat) y = (x < lo) ? lo : hi;
    else begin
      y = (x - lo) % m;
      if (y < 0) y = y + m;
      y = y + lo;
    end
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int mode = 0; mode < 2; mode++) begin
      longint acc, v;
      bit ovf, o;
      acc = 0;
      ovf = 1'b0;
      for (int i = 0; i < frame_a.size(); i++) begin
        fit(acc + align(frame_a[i] * frame_b[i], PEXP, ACC_EXP), ACC_W, mode == 0, acc, o);
        ovf = ovf | o;
      end
      fit(align(acc, ACC_EXP, OUT_EXP), OW, mode == 0, v, o);
      ovf = ovf | o;
      if (mode == 0) begin e.v_sat = v; e.o_sat = ovf; end
      else begin e.v_wrap = v; e.o_wrap = ovf; end
    end
    exp_q.push_back(e);
    frame_a.delete();
    frame_b.delete();
  endtask

  // Inputs change only at posedge+1; acceptance is decided from in_ready at negedge.
  task automatic send_beat(input longint a, input longint b, input bit last);
    int guard;
    bit took;
    guard = 0;
    took = 1'b0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(3) != 0);
    end
    a_value = AW'(a);
    b_value = BW'(b);
    in_last = last;
    in_valid = 1'b1;
    while (!took && guard < 200) begin
      @(negedge clk);
      took = in_ready_s;
      @(posedge clk); #1;
      guard++;
      if (rand_ready) out_ready = ($urandom_range(3) != 0);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    n_checks++;
    assert (took) else begin
      n_errors++;
      $error("FAIL accept_timeout: observed in_ready low for %0d cycles, required acceptance", guard);
    end
    if (took) begin
      frame_a.push_back(a);
      frame_b.push_back(b);
      if (last) push_expected();
    end
  endtask

  task automatic send_const_frame(input int n, input longint a, input longint b);
    for (int i = 0; i < n; i++) send_beat(a, b, i == n - 1);
  endtask

  task automatic send_rand_frame(input int n);
    logic signed [AW-1:0] ra;
    logic signed [BW-1:0] rb;
    for (int i = 0; i < n; i++) begin
      ra = AW'($urandom);
      rb = BW'($urandom);
      send_beat(ra, rb, i == n - 1);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    rand_ready = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_s && out_ready) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL spurious_result: observed value %0d with no frame outstanding", out_value_s);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        $display("result %0d: sat %0d ovf %0d | wrap %0d ovf %0d", n_results,
                 out_value_s, out_ovf_s, out_value_w, out_ovf_w);
        check("value_sat", out_value_s, e.v_sat);
        check("ovf_sat", out_ovf_s, e.o_sat);
        check("value_wrap", out_value_w, e.v_wrap);
        check("ovf_wrap", out_ovf_w, e.o_wrap);
        check("valid_wrap", out_valid_w, 1);
        check("in_ready_wrap", in_ready_w, 1);
        n_results++;
      end
    end
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_s, 0);
    check("rst_out_value", out_value_s, 0);
    check("rst_out_ovf", out_ovf_s, 0);
    check("rst_in_ready", in_ready_s, 1);
    rst_n = 1'b1;

    // Single-beat frame: 1.0 * 2.0, valid three edges after the accepting edge.
    send_beat(256, 1024, 1'b1);
    check("lat_k0", out_valid_s, 0);
    @(posedge clk); #1;
    check("lat_k1", out_valid_s, 0);
    @(posedge clk); #1;
    check("lat_k2", out_valid_s, 0);
    @(posedge clk); #1;
    check("lat_k3", out_valid_s, 1);
    check("lat_value", out_value_s, 2048);
    check("lat_ovf", out_ovf_s, 0);
    drain();

    // Back-to-back four-beat frames with no carry-over.
    send_const_frame(4, 128, 256);
    send_const_frame(4, -256, 256);
    drain();

    // Output-range overflow, then accumulator overflow.
    send_const_frame(2, 32767, 65535);
    drain();
    send_const_frame(260, -32768, -65536);
    drain();

    // Hold the result for five cycles while more beats are offered.
    out_ready = 1'b0;
    send_beat(300, -700, 1'b1);
    fork
      begin
        send_const_frame(3, 1000, 2000);
        send_beat(-5, 7, 1'b1);
      end
      begin
        guard = 0;
        while (!out_valid_s && guard < 30) begin
          @(posedge clk); #1;
          guard++;
        end
        check("stall_seen", out_valid_s, 1);
        for (int i = 0; i < 5; i++) begin
          check("stall_in_ready", in_ready_s, 0);
          check("stall_value", out_value_s, exp_q[0].v_sat);
          check("stall_ovf", out_ovf_s, exp_q[0].o_sat);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a frame discards it.
    send_beat(20000, 60000, 1'b0);
    send_beat(-20000, 60000, 1'b0);
    frame_a.delete();
    frame_b.delete();
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", out_valid_s, 0);
    check("mid_rst_value", out_value_s, 0);
    check("mid_rst_ovf", out_ovf_s, 0);
    check("mid_rst_in_ready", in_ready_s, 1);
    rst_n = 1'b1;
    send_beat(256, 512, 1'b1);
    drain();

    // Consecutive single-beat frames produce an unbroken run of results.
    fork
      begin
        send_rand_frame(1);
        send_rand_frame(1);
        send_rand_frame(1);
        send_rand_frame(1);
      end
      begin
        guard = 0;
        while (!out_valid_s && guard < 30) begin
          @(posedge clk); #1;
          guard++;
        end
        for (int i = 0; i < 4; i++) begin
          check("b2b_valid", out_valid_s, 1);
          @(posedge clk); #1;
        end
        check("b2b_end", out_valid_s, 0);
      end
    join
    drain();

    // Random frames with random gaps and consumer back-pressure.
    rand_ready = 1'b1;
    gap_pct = 20;
    for (int f = 0; f < 40; f++) send_rand_frame($urandom_range(1, 6));
    gap_pct = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
